// File: rtl/ppi_hs_pkg.sv
// ppi_hs_pkg: shared definitions for the ppi_hs parallel port block.
// It holds the control-word bit positions, the port C pin indices used by
// the mode-1 handshake, and the group mode enum.
// Optional feature macro: PPI_HS_INTR_EN (see ppi_hs.sv).
package ppi_hs_pkg;

  typedef enum logic {MODE0 = 1'b0, MODE1 = 1'b1} mode_e;

  // Mode-set control word (din[CW_MODE_SET] = 1)
  localparam int CW_PCL_IN    = 0;
  localparam int CW_B_IN      = 1;
  localparam int CW_B_MODE    = 2;
  localparam int CW_PCU_IN    = 3;
  localparam int CW_A_IN      = 4;
  localparam int CW_A_MODE_LO = 5;
  localparam int CW_A_MODE_HI = 6;
  localparam int CW_MODE_SET  = 7;

  // Mode-1 port C pin map
  localparam logic [2:0] PC_INTR_B = 3'd0;
  localparam logic [2:0] PC_IBF_B  = 3'd1;  // OBF_n when B is output
  localparam logic [2:0] PC_STB_B  = 3'd2;  // ACK_n when B is output
  localparam logic [2:0] PC_INTR_A = 3'd3;
  localparam logic [2:0] PC_STB_A  = 3'd4;
  localparam logic [2:0] PC_IBF_A  = 3'd5;
  localparam logic [2:0] PC_ACK_A  = 3'd6;
  localparam logic [2:0] PC_OBF_A  = 3'd7;

endpackage

// File: rtl/ppi_hs_chan.sv
// ppi_hs_chan: mode-1 handshake engine for one port (A or B).
// Synchronises the STB_n/ACK_n pin, detects its edges, and keeps the
// IBF / OBF_n / INTR / INTE flags plus the strobed input register.
// Ports:
//   clk, RESET      clock, synchronous active-high reset
//   clr             control mode-set write: drop all handshake state
//   mode, is_in     group mode and port direction
//   hs_n            raw STB_n (input) or ACK_n (output) pin
//   pins            port pin inputs, captured on the STB_n falling edge
//   rd_ev, rd_end   read access start / end aimed at this port
//   wr_ev           write access aimed at this port
//   inte_we/_wd     INTE bit-set write
//   ibf, obf_n, intr, inte, in_reg   handshake state
// With PPI_HS_INTR_EN undefined, intr and inte are constant 0.
module ppi_hs_chan
  import ppi_hs_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         clr,
  input  mode_e        mode,
  input  logic         is_in,
  input  logic         hs_n,
  input  logic [W-1:0] pins,
  input  logic         rd_ev,
  input  logic         rd_end,
  input  logic         wr_ev,
  input  logic         inte_we,
  input  logic         inte_wd,
  output logic         ibf,
  output logic         obf_n,
  output logic         intr,
  output logic         inte,
  output logic [W-1:0] in_reg
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hs_s, hs_prev, hs_fall, hs_rise, m1;

  assign hs_s    = sync[SYNC_STAGES-1];
  assign hs_fall = hs_prev & ~hs_s;
  assign hs_rise = ~hs_prev & hs_s;
  assign m1      = (mode == MODE1);

  // Synchroniser and edge history run in every mode so that entering
  // mode 1 never sees a stale level as an edge.
  always_ff @(posedge clk) begin
    if (RESET) begin
      sync    <= '1;
      hs_prev <= 1'b1;
    end else begin
      sync[0] <= hs_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      hs_prev <= hs_s;
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (RESET || clr) begin
      ibf   <= 1'b0;
      obf_n <= 1'b1;
    end else if (m1) begin
      if (is_in) begin
        if (hs_fall)     ibf <= 1'b1;
        else if (rd_end) ibf <= 1'b0;
      end else begin
        if (wr_ev)        obf_n <= 1'b0;
        else if (hs_fall) obf_n <= 1'b1;
      end
    end
  end

  // A new strobe while IBF is still set simply overwrites (overrun).
  always_ff @(posedge clk) begin
    if (RESET)                      in_reg <= '0;
    else if (m1 && is_in && hs_fall) in_reg <= pins;
  end

`ifdef PPI_HS_INTR_EN
  always_ff @(posedge clk) begin
    if (RESET || clr) begin
      intr <= 1'b0;
      inte <= 1'b0;
    end else begin
      if (inte_we) inte <= inte_wd;
      if (m1) begin
        if (is_in) begin
          if (hs_rise)    intr <= inte & ibf;
          else if (rd_ev) intr <= 1'b0;
        end else begin
          if (hs_rise)    intr <= inte & obf_n;
          else if (wr_ev) intr <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_intr;
  assign unused_intr = ^{rd_ev, inte_we, inte_wd, hs_rise};
  assign intr = 1'b0;
  assign inte = 1'b0;
`endif

endmodule

// File: rtl/ppi_hs.sv
// ppi_hs: programmable parallel interface with two W-bit ports (A, B),
// an 8-bit port C and an optional strobed handshake (mode 1) on A and B.
// Ports:
//   clk, RESET                 clock, synchronous active-high reset
//   cs_n, rd_n, wr_n, a, din   bus access (a: 0=A 1=B 2=C 3=control)
//   dout                       read data, 0 unless a read is active
//   pa_in/pa_out/pa_oe         port A pins, latch, drive enable (same for B)
//   pc_in/pc_out/pc_oe         port C pins, latch with handshake overlay, per-bit enable
//   intr_a, intr_b             interrupt requests
// Macro PPI_HS_INTR_EN enables the INTE/INTR logic; when undefined the
// interrupts are tied low and INTE writes are ignored.
module ppi_hs
  import ppi_hs_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         cs_n,
  input  logic         rd_n,
  input  logic         wr_n,
  input  logic [1:0]   a,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  input  logic [W-1:0] pa_in,
  input  logic [W-1:0] pb_in,
  output logic [W-1:0] pa_out,
  output logic [W-1:0] pb_out,
  output logic         pa_oe,
  output logic         pb_oe,
  input  logic [7:0]   pc_in,
  output logic [7:0]   pc_out,
  output logic [7:0]   pc_oe,
  output logic         intr_a,
  output logic         intr_b
);

  logic         a_in, b_in, pcl_in, pcu_in;
  mode_e        a_mode, b_mode;
  logic [W-1:0] pa_lat, pb_lat;
  logic [7:0]   pc_lat;

  // ---- access events: one per strobe ----
  logic       rd_pend, wr_pend, rd_ev, wr_ev, rd_end;
  logic [1:0] rd_a;

  assign rd_ev  = !cs_n && !rd_n && wr_n && !rd_pend;
  assign wr_ev  = !cs_n && !wr_n && rd_n && !wr_pend;
  assign rd_end = rd_pend && rd_n;

  always_ff @(posedge clk) begin
    if (RESET) begin
      rd_pend <= 1'b0;
      wr_pend <= 1'b0;
      rd_a    <= 2'd0;
    end else begin
      if (rd_ev) begin
        rd_pend <= 1'b1;
        rd_a    <= a;   // rd_end must go to the port that was read
      end else if (rd_end) begin
        rd_pend <= 1'b0;
      end
      if (wr_ev)     wr_pend <= 1'b1;
      else if (wr_n) wr_pend <= 1'b0;
    end
  end

  // ---- control word and output latches ----
  logic       mode_set, bit_set;
  logic [2:0] bsel;

  assign mode_set = wr_ev && (a == 2'd3) && din[CW_MODE_SET];
  assign bit_set  = wr_ev && (a == 2'd3) && !din[CW_MODE_SET];
  assign bsel     = din[3:1];

  always_ff @(posedge clk) begin
    if (RESET) begin
      a_in   <= 1'b1;
      b_in   <= 1'b1;
      pcl_in <= 1'b1;
      pcu_in <= 1'b1;
      a_mode <= MODE0;
      b_mode <= MODE0;
      pa_lat <= '0;
      pb_lat <= '0;
      pc_lat <= '0;
    end else if (mode_set) begin
      pcl_in <= din[CW_PCL_IN];
      b_in   <= din[CW_B_IN];
      b_mode <= din[CW_B_MODE] ? MODE1 : MODE0;
      pcu_in <= din[CW_PCU_IN];
      a_in   <= din[CW_A_IN];
      // Any nonzero A mode field selects mode 1.
      a_mode <= (|din[CW_A_MODE_HI:CW_A_MODE_LO]) ? MODE1 : MODE0;
      pa_lat <= '0;
      pb_lat <= '0;
      pc_lat <= '0;
    end else if (wr_ev) begin
      case (a)
        2'd0: pa_lat <= din;
        2'd1: pb_lat <= din;
        2'd2: pc_lat <= din[7:0];
        2'd3: pc_lat[bsel] <= din[0];
      endcase
    end
  end

  // ---- handshake channels ----
  logic         ibf_a, obf_n_a, intr_a_i, inte_a, ibf_b, obf_n_b, intr_b_i, inte_b;
  logic [W-1:0] in_reg_a, in_reg_b;
  logic         inte_we_a, inte_we_b;

  // INTE shares its bit position with the STB_n/ACK_n pin of that port.
  assign inte_we_a = bit_set && (a_mode == MODE1) &&
                     (a_in ? (bsel == PC_STB_A) : (bsel == PC_ACK_A));
  assign inte_we_b = bit_set && (b_mode == MODE1) && (bsel == PC_STB_B);

  ppi_hs_chan #(.W(W), .SYNC_STAGES(SYNC_STAGES)) u_chan_a (
    .clk     (clk),
    .RESET   (RESET),
    .clr     (mode_set),
    .mode    (a_mode),
    .is_in   (a_in),
    .hs_n    (a_in ? pc_in[PC_STB_A] : pc_in[PC_ACK_A]),
    .pins    (pa_in),
    .rd_ev   (rd_ev && (a == 2'd0)),
    .rd_end  (rd_end && (rd_a == 2'd0)),
    .wr_ev   (wr_ev && (a == 2'd0)),
    .inte_we (inte_we_a),
    .inte_wd (din[0]),
    .ibf     (ibf_a),
    .obf_n   (obf_n_a),
    .intr    (intr_a_i),
    .inte    (inte_a),
    .in_reg  (in_reg_a)
  );

  ppi_hs_chan #(.W(W), .SYNC_STAGES(SYNC_STAGES)) u_chan_b (
    .clk     (clk),
    .RESET   (RESET),
    .clr     (mode_set),
    .mode    (b_mode),
    .is_in   (b_in),
    .hs_n    (pc_in[PC_STB_B]),
    .pins    (pb_in),
    .rd_ev   (rd_ev && (a == 2'd1)),
    .rd_end  (rd_end && (rd_a == 2'd1)),
    .wr_ev   (wr_ev && (a == 2'd1)),
    .inte_we (inte_we_b),
    .inte_wd (din[0]),
    .ibf     (ibf_b),
    .obf_n   (obf_n_b),
    .intr    (intr_b_i),
    .inte    (inte_b),
    .in_reg  (in_reg_b)
  );

  // ---- port outputs ----
  assign pa_out = pa_lat;
  assign pb_out = pb_lat;
  assign pa_oe  = !a_in;
  assign pb_oe  = !b_in;
  assign intr_a = intr_a_i;
  assign intr_b = intr_b_i;

  // Port C: plain latch/pin per group, then the mode-1 handshake bits
  // are overlaid on the drive value, the enable and the read-back value.
  logic [7:0] pc_out_c, pc_oe_c, pc_rd;

  always_comb begin
    pc_out_c = pc_lat;
    pc_oe_c  = {{4{!pcu_in}}, {4{!pcl_in}}};
    pc_rd    = (pc_lat & pc_oe_c) | (pc_in & ~pc_oe_c);
    if (a_mode == MODE1) begin
      pc_out_c[PC_INTR_A] = intr_a_i;
      pc_oe_c[PC_INTR_A]  = 1'b1;
      pc_rd[PC_INTR_A]    = intr_a_i;
      if (a_in) begin
        pc_out_c[PC_IBF_A] = ibf_a;
        pc_oe_c[PC_STB_A]  = 1'b0;
        pc_oe_c[PC_IBF_A]  = 1'b1;
        pc_rd[PC_STB_A]    = inte_a;
        pc_rd[PC_IBF_A]    = ibf_a;
      end else begin
        pc_out_c[PC_OBF_A] = obf_n_a;
        pc_oe_c[PC_ACK_A]  = 1'b0;
        pc_oe_c[PC_OBF_A]  = 1'b1;
        pc_rd[PC_ACK_A]    = inte_a;
        pc_rd[PC_OBF_A]    = obf_n_a;
      end
    end
    if (b_mode == MODE1) begin
      pc_out_c[PC_INTR_B] = intr_b_i;
      pc_out_c[PC_IBF_B]  = b_in ? ibf_b : obf_n_b;
      pc_oe_c[PC_INTR_B]  = 1'b1;
      pc_oe_c[PC_IBF_B]   = 1'b1;
      pc_oe_c[PC_STB_B]   = 1'b0;
      pc_rd[PC_INTR_B]    = intr_b_i;
      pc_rd[PC_IBF_B]     = b_in ? ibf_b : obf_n_b;
      pc_rd[PC_STB_B]     = inte_b;
    end
  end

  assign pc_out = pc_out_c;
  assign pc_oe  = pc_oe_c;

  // ---- read mux ----
  logic [7:0] ctrl_rd;
  assign ctrl_rd = {1'b1, 1'b0, a_mode == MODE1, a_in, pcu_in, b_mode == MODE1, b_in, pcl_in};

  always_comb begin
    dout = '0;
    if (!cs_n && !rd_n) begin
      case (a)
        2'd0: dout = a_in ? ((a_mode == MODE1) ? in_reg_a : pa_in) : pa_lat;
        2'd1: dout = b_in ? ((b_mode == MODE1) ? in_reg_b : pb_in) : pb_lat;
        2'd2: dout = W'(pc_rd);
        2'd3: dout = W'(ctrl_rd);
      endcase
    end
  end

endmodule
